seq_pattern_tx: RTL and testbench

// Serial pattern transmitter: the driving end of the 1-bit `in` line sampled by the "101" Mealy detector.
// - Accepts a WIDTH-bit word over a start/ready handshake and shifts it out MSB-first, one bit per clk.
// - Appends GAP_CYCLES zero bits after each frame.
// - Reports match_cnt, the number of overlapping "101" occurrences in the frame, so benches and

---
 rtl/seq_pkg.sv | 8 +
 rtl/seq101_tracker.sv | 29 ++
 rtl/seq_pattern_tx.sv | 69 ++++++
 tb/tb_seq_pattern_tx.sv | 131 +++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding, pattern constant and count-width helper for the pattern transmitter
package seq_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2} state_t;
   localparam logic [2:0] PATTERN = 3'b101;
   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction
endpackage

// File: rtl/seq101_tracker.sv
// seq101_tracker: counts overlapping "101" occurrences in a gated bit stream
module seq101_tracker
   import seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          clear,
   input  logic                          bit_en,
   input  logic                          bit_val,
   output logic [cnt_width(WIDTH)-1:0]   count
);
   localparam int CW = cnt_width(WIDTH);
   logic [1:0] history;
   always_ff @(posedge clk) begin
      if (reset) begin
         history <= 2'b00;
         count   <= '0;
      end else if (clear) begin
         // the first frame bit arrives with the clear and can never complete a match
         history <= {1'b0, bit_en & bit_val};
         count   <= '0;
      end else if (bit_en) begin
         history <= {history[0], bit_val};
         if ({history, bit_val} == PATTERN) count <= count + CW'(1);
      end
   end
endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: MSB-first serial frame transmitter with zero gap and "101" hit count
module seq_pattern_tx
   import seq_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int GAP_CYCLES = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [WIDTH-1:0]              data_in,
   input  logic                          start,
   output logic                          ready,
   output logic                          out,
   output logic                          valid,
   output logic                          done,
   output logic [cnt_width(WIDTH)-1:0]   match_cnt
);
   localparam int BW = $clog2(WIDTH);
   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg;
   logic [BW-1:0]    bit_cnt;
   logic [3:0]       gap_cnt;
   logic             accept, last_bit, gap_end, bit_en, bit_val;
   always_comb begin
      accept    = (state == IDLE) && start;
      last_bit  = (state == SHIFT) && (bit_cnt == '0);
      gap_end   = (state == GAP) && (gap_cnt == 4'd0);
      bit_en    = accept || ((state == SHIFT) && !last_bit);
      bit_val   = accept ? data_in[WIDTH-1] : shreg[WIDTH-1];
      state_nxt = accept ? SHIFT : last_bit ? GAP : gap_end ? IDLE : state;
   end
   assign ready = (state == IDLE);
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end
   // shreg[WIDTH-1] always holds the next bit to present on out
   always_ff @(posedge clk) begin
      if (reset) begin
         shreg   <= '0;
         bit_cnt <= '0;
         gap_cnt <= '0;
         out     <= 1'b0;
         valid   <= 1'b0;
         done    <= 1'b0;
      end else begin
         done  <= gap_end;
         out   <= bit_en & bit_val;
         valid <= bit_en;
         if (accept) begin
            shreg   <= data_in << 1;
            bit_cnt <= BW'(WIDTH - 1);
         end else if (bit_en) begin
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt - BW'(1);
         end
         if (last_bit)           gap_cnt <= 4'(GAP_CYCLES - 1);
         else if (state == GAP)  gap_cnt <= gap_cnt - 4'd1;
      end
   end
   seq101_tracker #(.WIDTH(WIDTH)) u_tracker (
      .clk     (clk),
      .reset   (reset),
      .clear   (accept),
      .bit_en  (bit_en),
      .bit_val (bit_val),
      .count   (match_cnt)
   );
endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: vector table, hand-built corner sequences and random frames against a stream model
module tb_seq_pattern_tx;
   localparam int W = 8;
   localparam int G = 2;
   logic         clk = 1'b0;
   logic         reset, start, ready, out, valid, done;
   logic [W-1:0] data_in;
   logic [3:0]   match_cnt;
   int           checks = 0, failures = 0, hits = 0;
   logic [2:0]   win = 3'b000;
   typedef struct {logic [W-1:0] w; int exp; int poke;} vec_t;
   vec_t tv[7];

   seq_pattern_tx #(.WIDTH(W), .GAP_CYCLES(G)) dut (
      .clk(clk), .reset(reset), .data_in(data_in), .start(start), .ready(ready),
      .out(out), .valid(valid), .done(done), .match_cnt(match_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // detector stand-in: sliding 3-bit window over every cycle of out
   task automatic tick();
      @(posedge clk);
      #1;
      win = {win[1:0], out};
      if (win == 3'b101) hits++;
   endtask

   function automatic int count101(input logic [W-1:0] w);
      int n = 0;
      for (int i = 0; i <= W - 3; i++) if (((w >> i) & 7) == 5) n++;
      return n;
   endfunction

   task automatic send_frame(input logic [W-1:0] w, input int exp, input string nm, input int poke);
      int h0;
      h0 = hits;
      check($sformatf("%s ready", nm), {31'd0, ready}, 1);
      data_in = w;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      data_in = W'($urandom);
      for (int i = 0; i < W; i++) begin
         check($sformatf("%s bit%0d {valid,out,ready}", nm, i), {29'd0, valid, out, ready},
               {29'd0, 1'b1, w[W-1-i], 1'b0});
         if (i == poke) begin
            start   = 1'b1;
            data_in = W'($urandom);
         end
         tick();
         start = 1'b0;
      end
      for (int g = 0; g < G; g++) begin
         check($sformatf("%s gap%0d {valid,out,done,ready}", nm, g), {28'd0, valid, out, done, ready}, 0);
         tick();
      end
      check($sformatf("%s done/ready", nm), {30'd0, done, ready}, 3);
      check($sformatf("%s match_cnt", nm), {28'd0, match_cnt}, exp);
      check($sformatf("%s detector hits", nm), hits - h0, {28'd0, match_cnt});
   endtask

   initial begin
      tv[0] = '{8'b1010_1101, 3, -1};
      tv[1] = '{8'b1011_0101, 3, -1};
      tv[2] = '{8'h00, 0, -1};
      tv[3] = '{8'hFF, 0, -1};
      tv[4] = '{8'h55, 3, -1};
      tv[5] = '{8'h05, 1, -1};
      tv[6] = '{8'hA5, 2, 3};
      reset = 1'b1; start = 1'b0; data_in = '0;
      tick();
      tick();
      reset = 1'b0;
      check("reset {ready,out,valid,done}", {28'd0, ready, out, valid, done}, 4'b1000);
      check("reset match_cnt", {28'd0, match_cnt}, 0);
      tick();
      check("idle after reset", {28'd0, ready, out, valid, done}, 4'b1000);
      for (int v = 0; v < 7; v++) send_frame(tv[v].w, tv[v].exp, $sformatf("vec%0d", v), tv[v].poke);
      tick();
      check("single done pulse", {31'd0, done}, 0);
      check("match_cnt held", {28'd0, match_cnt}, 2);
      // reset while the 4th bit of 8'hAA is on out
      data_in = 8'hAA; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("rst frame bit%0d", i), {30'd0, valid, out}, {30'd0, 1'b1, ~1'(i % 2)});
         if (i < 3) tick();
      end
      check("match_cnt before reset", {28'd0, match_cnt}, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid-frame reset outputs", {28'd0, ready, out, valid, done}, 4'b1000);
      check("mid-frame reset match_cnt", {28'd0, match_cnt}, 0);
      for (int i = 0; i < W + G + 2; i++) begin
         tick();
         check($sformatf("no done after reset %0d", i), {29'd0, done, valid, ready}, 1);
      end
      reset = 1'b1; start = 1'b1; data_in = 8'hFF;
      tick();
      reset = 1'b0; start = 1'b0;
      check("reset beats start ready", {30'd0, ready, valid}, 2);
      tick();
      check("reset beats start nothing sent", {30'd0, ready, valid}, 2);
      for (int f = 0; f < 20; f++) begin
         logic [W-1:0] w;
         int idle, poke;
         w    = W'($urandom);
         idle = $urandom_range(0, 2);
         poke = $urandom_range(0, 1) ? int'($urandom_range(0, W - 1)) : -1;
         for (int i = 0; i < idle; i++) begin
            tick();
            check($sformatf("rand%0d idle", f), {30'd0, done, ready}, 1);
         end
         send_frame(w, count101(w), $sformatf("rand%0d", f), poke);
      end
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
